// File: rtl/jtframe_pll_seq_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package jtframe_pll_seq_pkg;

    localparam int DEF_RSTW   = 16;
    localparam int DEF_STABLE = 1024;
    localparam int DEF_TOUT   = 2500000;
    localparam int DEF_CW     = 24;

    typedef enum logic [1:0] {
        PRST   = 2'd0,
        WAIT   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } pll_state_t;

endpackage

// File: rtl/jtframe_pll_lock_sync.sv
// Two-flop synchroniser with synchronous clear, for asynchronous status inputs.
module jtframe_pll_lock_sync (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], din};
        end
    end

    assign dout = sync_reg[1];

endmodule

// File: rtl/jtframe_pll_seq.sv
// PLL reset sequencer and core reset generator with lock timeout and relock counter.
// Optional macro JTFRAME_PLL_RETRY_EN: timeouts and lock losses re-pulse the PLL reset.
module jtframe_pll_seq
    import jtframe_pll_seq_pkg::*;
#(
    parameter int RSTW   = DEF_RSTW,
    parameter int STABLE = DEF_STABLE,
    parameter int TOUT   = DEF_TOUT,
    parameter int CW     = DEF_CW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       timeout,
    output logic [7:0] relocks
);

    localparam longint CNT_LIMIT = longint'(1) << CW;

    generate
        if (RSTW < 2 || STABLE < 2 || TOUT < 2 ||
            longint'(RSTW) >= CNT_LIMIT || longint'(STABLE) >= CNT_LIMIT ||
            longint'(TOUT) >= CNT_LIMIT) begin : g_param_err
            $error("jtframe_pll_seq: RSTW, STABLE and TOUT must be >= 2 and < 2**CW");
        end
    endgenerate

    localparam logic [CW-1:0] RSTW_LAST   = CW'(RSTW - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE - 1);
    localparam logic [CW-1:0] TOUT_LAST   = CW'(TOUT - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    logic          lock_s;
    pll_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          pll_rst_reg, pll_rst_next;
    logic          sys_rst_reg, sys_rst_next;
    logic          timeout_reg, timeout_next;
    logic [7:0]    relocks_reg, relocks_next;

    jtframe_pll_lock_sync u_lock_sync (
        .clk  (clk),
        .clr  (rst),
        .din  (locked),
        .dout (lock_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= PRST;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b1;
            sys_rst_reg <= 1'b1;
            timeout_reg <= 1'b0;
            relocks_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pll_rst_reg <= pll_rst_next;
            sys_rst_reg <= sys_rst_next;
            timeout_reg <= timeout_next;
            relocks_reg <= relocks_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pll_rst_next = pll_rst_reg;
        sys_rst_next = sys_rst_reg;
        timeout_next = timeout_reg;
        relocks_next = relocks_reg;
        case (state_reg)
            PRST: begin
                pll_rst_next = 1'b1;
                sys_rst_next = 1'b1;
                if (cnt_reg == RSTW_LAST) begin
                    state_next   = WAIT;
                    cnt_next     = '0;
                    pll_rst_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            WAIT: begin
                pll_rst_next = 1'b0;
                sys_rst_next = 1'b1;
                if (lock_s) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end else if (cnt_reg == TOUT_LAST) begin
                    timeout_next = 1'b1;
                    cnt_next     = '0;
`ifdef JTFRAME_PLL_RETRY_EN
                    state_next   = PRST;
                    pll_rst_next = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            SETTLE: begin
                sys_rst_next = 1'b1;
                // A lock glitch restarts the whole settle period without counting as a relock
                if (!lock_s) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next   = RUN;
                    cnt_next     = '0;
                    sys_rst_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            RUN: begin
                cnt_next     = '0;
                sys_rst_next = 1'b0;
                if (!lock_s) begin
                    sys_rst_next = 1'b1;
                    if (relocks_reg != 8'hFF) begin
                        relocks_next = relocks_reg + 8'd1;
                    end
`ifdef JTFRAME_PLL_RETRY_EN
                    state_next   = PRST;
                    pll_rst_next = 1'b1;
`else
                    state_next   = WAIT;
`endif
                end
            end
            default: begin
                state_next = PRST;
                cnt_next   = '0;
            end
        endcase
    end

    assign pll_rst = pll_rst_reg;
    assign sys_rst = sys_rst_reg;
    assign ready   = ~sys_rst_reg;
    assign timeout = timeout_reg;
    assign relocks = relocks_reg;

endmodule

// File: tb/tb_jtframe_pll_seq.sv
// Self-checking bench for jtframe_pll_seq with short timing parameters.
module tb_jtframe_pll_seq;

    localparam int RSTW   = 4;
    localparam int STABLE = 8;
    localparam int TOUT   = 32;
    localparam int CW     = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst, sys_rst, ready, timeout;
    logic [7:0] relocks;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    jtframe_pll_seq #(
        .RSTW   (RSTW),
        .STABLE (STABLE),
        .TOUT   (TOUT),
        .CW     (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .locked  (locked),
        .pll_rst (pll_rst),
        .sys_rst (sys_rst),
        .ready   (ready),
        .timeout (timeout),
        .relocks (relocks)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Edges until pll_rst is seen low; bounded
    task automatic count_pll_pulse(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Edges until sys_rst is seen low; bounded
    task automatic count_until_run(output int n);
        n = 0;
        while (sys_rst !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        locked = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0 ||
            timeout !== 1'b0 || relocks !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: got pll_rst=%b sys_rst=%b ready=%b timeout=%b relocks=%0d, need 1 1 0 0 0",
                     pll_rst, sys_rst, ready, timeout, relocks);
        end
        $display("reset_state: pll_rst=%b sys_rst=%b ready=%b", pll_rst, sys_rst, ready);
    endtask

    task automatic test_lock;
        int n, e;
        locked = 1'b0;
        exp_q.push_back(RSTW);
        do_reset();
        count_pll_pulse(n);
        e = exp_q.pop_front();
        n_checks++;
        if (n !== e) begin
            n_fail++;
            $display("FAIL pll_rst_width: got %0d edges, need %0d", n, e);
        end
        repeat (10) tick();
        locked = 1'b1;
        exp_q.push_back(STABLE + 2);
        tick();
        count_until_run(n);
        e = exp_q.pop_front();
        n_checks++;
        if (n !== e) begin
            n_fail++;
            $display("FAIL lock_release: sys_rst fell %0d edges after e0, need %0d", n, e);
        end
        n_checks++;
        if (ready !== 1'b1 || relocks !== 8'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_status: got ready=%b relocks=%0d timeout=%b, need 1 0 0", ready, relocks, timeout);
        end
        $display("lock: sys_rst released %0d edges after first lock sample", n);
    endtask

    task automatic test_settle_glitch;
        int n, e;
        locked = 1'b0;
        do_reset();
        count_pll_pulse(n);
        locked = 1'b1;
        // Lock drops for one cycle once cnt reaches 5; restored sample lands at e0+9
        exp_q.push_back(9 + STABLE + 2);
        tick();
        n = 0;
        while (n < 200) begin
            if (n == 7) locked = 1'b0;
            if (n == 8) locked = 1'b1;
            tick();
            n++;
            if (sys_rst === 1'b0) break;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (n !== e) begin
            n_fail++;
            $display("FAIL settle_glitch: sys_rst fell %0d edges after e0, need %0d", n, e);
        end
        n_checks++;
        if (relocks !== 8'd0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL settle_glitch_status: got relocks=%0d ready=%b, need 0 1", relocks, ready);
        end
        $display("settle_glitch: release at e0+%0d", n);
    endtask

    task automatic test_timeout;
        int n, e, bad;
        locked = 1'b0;
        do_reset();
        count_pll_pulse(n);
        exp_q.push_back(TOUT);
        n = 0;
        while (timeout !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (n !== e) begin
            n_fail++;
            $display("FAIL timeout_delay: timeout after %0d WAIT edges, need %0d", n, e);
        end
`ifdef JTFRAME_PLL_RETRY_EN
        n_checks++;
        if (pll_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_retry: got pll_rst=%b, need 1", pll_rst);
        end
        exp_q.push_back(RSTW);
        count_pll_pulse(n);
        e = exp_q.pop_front();
        n_checks++;
        if (n !== e) begin
            n_fail++;
            $display("FAIL timeout_repulse: pll_rst high %0d edges, need %0d", n, e);
        end
`else
        bad = 0;
        repeat (2 * TOUT + 4) begin
            tick();
            if (pll_rst !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL timeout_no_repulse: pll_rst high on %0d edges, need 0", bad);
        end
`endif
        n_checks++;
        if (timeout !== 1'b1 || sys_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got timeout=%b sys_rst=%b, need 1 1", timeout, sys_rst);
        end
        $display("timeout: fired after %0d WAIT edges", TOUT);
    endtask

    task automatic test_lock_during_reset;
        int n, e;
        locked = 1'b1;
        exp_q.push_back(RSTW);
        exp_q.push_back(RSTW + 1 + STABLE);
        do_reset();
        count_pll_pulse(n);
        e = exp_q.pop_front();
        n_checks++;
        if (n !== e) begin
            n_fail++;
            $display("FAIL held_lock_pulse: pll_rst high %0d edges, need %0d", n, e);
        end
        count_until_run(n);
        e = exp_q.pop_front() - RSTW;
        n_checks++;
        if (n !== e) begin
            n_fail++;
            $display("FAIL held_lock_release: sys_rst fell %0d edges after pll_rst, need %0d", n, e);
        end
        $display("held_lock: release %0d edges after pll_rst fell", n);
    endtask

    task automatic test_relock_sat;
        int n, e;
        locked = 1'b1;
        do_reset();
        count_until_run(n);
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back((i + 1 > 255) ? 255 : i + 1);
            locked = 1'b0;
            tick();
            tick();
            n_checks++;
            if (sys_rst !== 1'b0) begin
                n_fail++;
                $display("FAIL relock_early[%0d]: sys_rst=%b at e0+1, need 0", i, sys_rst);
            end
            tick();
            n_checks++;
            if (sys_rst !== 1'b1 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL relock_drop[%0d]: sys_rst=%b ready=%b at e0+2, need 1 0", i, sys_rst, ready);
            end
            e = exp_q.pop_front();
            n_checks++;
            if (relocks !== 8'(e)) begin
                n_fail++;
                $display("FAIL relock_count[%0d]: got %0d, need %0d", i, relocks, e);
            end
            locked = 1'b1;
            count_until_run(n);
            n_checks++;
            if (sys_rst !== 1'b0) begin
                n_fail++;
                $display("FAIL relock_rerun[%0d]: no release after %0d edges", i, n);
            end
            if (i % 50 == 0 || i >= 298)
                $display("relock %0d: relocks=%0d", i, relocks);
        end
    endtask

    task automatic test_rst_vs_timeout;
        int n, e;
        locked = 1'b0;
        n = 0;
`ifdef JTFRAME_PLL_RETRY_EN
        while (pll_rst !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        count_pll_pulse(n);
`else
        while (sys_rst !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
`endif
        repeat (TOUT - 1) tick();
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_timeout: got timeout=%b one edge early, need 0", timeout);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (timeout !== 1'b0 || relocks !== 8'd0 || pll_rst !== 1'b1 || sys_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_vs_timeout: got timeout=%b relocks=%0d pll_rst=%b sys_rst=%b, need 0 0 1 1",
                     timeout, relocks, pll_rst, sys_rst);
        end
        rst = 1'b0;
        exp_q.push_back(RSTW);
        count_pll_pulse(n);
        e = exp_q.pop_front();
        n_checks++;
        if (n !== e) begin
            n_fail++;
            $display("FAIL rst_restart_pulse: pll_rst high %0d edges, need %0d", n, e);
        end
        $display("rst_vs_timeout: restart pulse %0d edges", n);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_settle_glitch();
        test_timeout();
        test_lock_during_reset();
        test_relock_sat();
        test_rst_vs_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtframe_pll_seq.md
# jtframe_pll_seq

The block sequences the system PLL and generates the core-wide reset.
- It pulses the PLL reset, then waits for `locked` with a timeout.
- It requires lock to stay high for a fixed settle period before releasing `sys_rst`.
- On loss of lock it re-asserts `sys_rst`, and it counts relock events for the debug/OSD status bus.
- It sits between the board oscillator domain and the PLL wrapper, clocked by the reference clock.

## Interface
Parameters:
- `RSTW`, 16: PLL reset pulse length, in clk cycles.
- `STABLE`, 1024: cycles `locked` must stay continuously high before `sys_rst` releases.
- `TOUT`, 2500000: cycles to wait for lock before timeout (50 ms at 50 MHz).
- `CW`, 24: shared counter width.
  - `RSTW`, `STABLE` and `TOUT` are each ≥2 and <2^CW.
  - This is checked at elaboration.

Ports:
- `clk` in 1: reference clock, same net as the PLL refclk.
- `rst` in 1: synchronous, active-high reset.
- `locked` in 1: PLL lock. Asynchronous to `clk`; synchronised internally.
- `pll_rst` out 1: PLL reset, registered.
- `sys_rst` out 1: core reset, registered, active-high.
- `ready` out 1: high only in RUN. Equals `~sys_rst`.
- `timeout` out 1: sticky. Set on the first lock timeout; cleared only by `rst`.
- `relocks` out 8: saturating count of lock losses seen in RUN.

## Operation
- `locked` passes through a 2-flop synchroniser. The output is `lock_s`.
- States are PRST, WAIT, SETTLE and RUN. One counter `cnt[CW-1:0]` is shared by all states.
- On `rst` high:
  - state=PRST, cnt=0.
  - `pll_rst`=1, `sys_rst`=1, `ready`=0, `timeout`=0, `relocks`=0.
  - Synchroniser flops are cleared to 0.
- PRST:
  - `pll_rst`=1, `sys_rst`=1, and cnt increments.
  - At cnt==RSTW-1: go to WAIT, cnt=0, `pll_rst`=0.
- WAIT:
  - `sys_rst`=1.
  - If `lock_s`=1: go to SETTLE, cnt=0.
  - Otherwise cnt increments. At cnt==TOUT-1: `timeout`=1, plus the macro-dependent action below.
- SETTLE:
  - If `lock_s`=0: go to WAIT, cnt=0. No count change; this is a glitch during settle.
  - At cnt==STABLE-1 with `lock_s`=1: go to RUN, `sys_rst`=0, `ready`=1.
- RUN:
  - On `lock_s`=0: `sys_rst`=1 and `ready`=0 at that edge.
  - `relocks` increments, saturating at 255.
  - Next state is macro-dependent.
- Simultaneous events: `rst` overrides everything, including a timeout or lock loss on the same edge.
- Reset mid-operation restarts at PRST, so the PLL reset is re-pulsed unconditionally.
- The counter never wraps. Every state exits or reloads it before it reaches 2^CW-1.

## Timing
- After `rst` falls, `pll_rst` stays high for exactly RSTW more edges.
- Take edge e0 as the first edge that samples `locked`=1 while in WAIT, with `locked` held high afterwards. `sys_rst` falls after edge e0+STABLE+2.
- Lock loss: `locked` falls before edge e0. `sys_rst` is high after e0+2, two synchroniser cycles plus a registered output.
- In WAIT, timeout fires TOUT edges after entering WAIT.
- All outputs are registered. There are no combinational paths from `locked` to any output.

## Configuration
- `JTFRAME_PLL_RETRY_EN` defined:
  - A WAIT timeout goes to PRST with cnt=0, re-pulsing `pll_rst`.
  - Lock loss in RUN goes to PRST.
- Not defined:
  - A WAIT timeout sets `timeout`, reloads cnt=0 and stays in WAIT.
  - Lock loss in RUN goes to WAIT.
  - `pll_rst` is never re-asserted except by `rst`.

## Structure
- Package `jtframe_pll_seq_pkg`:
  - State enum: PRST, WAIT, SETTLE, RUN.
  - Default constants for RSTW, STABLE, TOUT and CW.
- Sub-module `jtframe_pll_lock_sync`: the 2-flop synchroniser with synchronous clear. Reusable for other async status inputs.
- The rest is a single FSM-plus-counter process.

## Test plan
All scenarios use RSTW=4, STABLE=8, TOUT=32.
- Release `rst`, then raise `locked` 10 cycles after `pll_rst` falls -> `pll_rst` high 4 edges after `rst` falls; `sys_rst` falls 10 edges after `locked` is first sampled; `ready`=1; `relocks`=0.
- In SETTLE, drop `locked` for 1 cycle at cnt=5, then restore -> state returns to WAIT and the settle period restarts; `sys_rst` stays high; `relocks`=0.
- Keep `locked` low -> `timeout`=1 after 32 WAIT edges.
  - With the macro: `pll_rst` re-pulses for 4 cycles.
  - Without the macro: `pll_rst` stays 0.
- In RUN, drop `locked` 300 times with relock in between -> `relocks` saturates at 255; `sys_rst` is high 2 edges after each drop.
- Assert `rst` in the same cycle as a WAIT timeout -> the next state is PRST; `timeout`=0 and `relocks`=0.
- Hold `locked` high throughout reset -> the PLL reset is still pulsed; `sys_rst` stays high until the full 4+settle sequence completes.
